// File: rtl/hs_ad_capture.sv
// High-speed ADC capture: divided sample clock, input register, level-crossing
// trigger and a fixed-length record buffer behind a synchronous read port.
module hs_ad_capture #(
  parameter int unsigned DATA_W  = 10,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ad_clk,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              start,
  input  logic              abort,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_level,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_cnt,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HALF  = CLK_DIV / 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_TRIG,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_nxt_c;
  logic              smp_en_c;
  logic              smp_vld;
  logic [DATA_W-1:0] sample;
  logic [DATA_W-1:0] prev_sample;
  logic              first_q;
  logic              fire_c;
  logic              we_c;
  logic [ADDR_W-1:0] waddr_c;
  logic [DATA_W-1:0] ram [DEPTH];

  // Divider next value; the strobe sits in the last cycle of the ad_clk high phase
  always_comb begin
    smp_en_c  = (div_cnt == DIV_W'(CLK_DIV - 1));
    div_nxt_c = smp_en_c ? '0 : div_cnt + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      ad_clk  <= 1'b0;
    end else begin
      div_cnt <= div_nxt_c;
      ad_clk  <= (div_nxt_c >= DIV_W'(HALF));
    end
  end

  // Input register and one-sample history for crossing detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_vld     <= 1'b0;
      sample      <= '0;
      prev_sample <= '0;
    end else begin
      smp_vld <= smp_en_c;
      if (smp_en_c) sample <= ad_data;
      if (smp_vld) prev_sample <= sample;
    end
  end

  // Trigger and write decode; abort suppresses any write in its cycle
  always_comb begin
    fire_c  = 1'b0;
    we_c    = 1'b0;
    waddr_c = '0;
    if (smp_vld && !abort) begin
      if (state == S_WAIT_TRIG) begin
        fire_c = trig_en ? (!first_q && (prev_sample < trig_level) && (sample >= trig_level))
                         : 1'b1;
        we_c   = fire_c;
      end else if (state == S_CAPTURE) begin
        we_c    = 1'b1;
        waddr_c = wr_cnt[ADDR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_cnt  <= '0;
      first_q <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_WAIT_TRIG;
            busy    <= 1'b1;
            done    <= 1'b0;
            wr_cnt  <= '0;
            first_q <= 1'b1;
          end
        end
        S_WAIT_TRIG: begin
          // first sample after arming only seeds the history
          if (smp_vld) begin
            first_q <= 1'b0;
            if (fire_c) begin
              state  <= S_CAPTURE;
              wr_cnt <= CNT_W'(1);
            end
          end
        end
        S_CAPTURE: begin
          if (smp_vld) begin
            wr_cnt <= wr_cnt + CNT_W'(1);
            if (wr_cnt == CNT_W'(DEPTH - 1)) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Record buffer: one write port, one registered read port
  always_ff @(posedge clk) begin
    if (we_c) ram[waddr_c] <= sample;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= ram[rd_addr];
  end

endmodule
